imem_loader: RTL

- Boot-time writer for the instruction memory that the single-cycle CPU reads from.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to consecutive word-aligned byte addresses, then verifies an XOR checksum.
- Holds the CPU (cpu_hold) until the image is loaded and verified; the CPU then starts fetching from pc = BASE_ADDR.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader_byte_word_assembler.sv | 30 +++
 rtl/imem_loader.sv | 115 +++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    CSUM,
    DONE,
    ERR
  } loaderState_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake, instruction-memory write port and CPU status lines.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              imem_we;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  // Loader side.
  modport master (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
  );

  // Stream source / memory / CPU side.
  modport slave (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
  );

endinterface

// File: rtl/imem_loader_byte_word_assembler.sv
// Collects big-endian bytes into 32-bit words; wordValid marks the transfer carrying the last byte.
module imem_loader_byte_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              xfer,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              wordValid
);

  // Only the three earlier bytes need storing; the fourth is used straight from the bus.
  logic [WORD_W-BYTE_W-1:0] sr;
  logic [1:0]               byteCnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '0;
      byteCnt <= '0;
    end else if (xfer) begin
      sr      <= {sr[WORD_W-2*BYTE_W-1:0], data};
      byteCnt <= byteCnt + 2'd1;
    end
  end

  assign word      = {sr, data};
  assign wordValid = xfer && (byteCnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header count, payload words written to instruction memory, then XOR checksum check.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.master bus
);

  localparam logic [WORD_W-1:0] MAX_COUNT = WORD_W'(MAX_WORDS);

  loaderState_t      state, stateNext;
  logic              readyEn;
  logic [WORD_W-1:0] wordIdx, wordIdxNext;
  logic [WORD_W-1:0] wordsLeft, wordsLeftNext;
  logic [WORD_W-1:0] csum, csumNext;
  logic              we, weNext;
  logic [WORD_W-1:0] addr, addrNext;
  logic [WORD_W-1:0] wdata, wdataNext;
  logic              xfer;
  logic [WORD_W-1:0] word;
  logic              wordValid;

  imem_loader_byte_word_assembler u_assembler (
    .clk       (clk),
    .rst_n     (rst_n),
    .xfer      (xfer),
    .data      (bus.in_data),
    .word      (word),
    .wordValid (wordValid)
  );

  // readyEn keeps the loader deaf for exactly one cycle after reset.
  assign bus.in_ready   = readyEn && (state == HDR || state == LOAD || state == CSUM);
  assign xfer           = bus.in_valid && bus.in_ready;
  assign bus.imem_we    = we;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = wdata;
  assign bus.done       = (state == DONE);
  assign bus.err        = (state == ERR);
  assign bus.cpu_hold   = (state != DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= HDR;
      readyEn   <= 1'b0;
      wordIdx   <= '0;
      wordsLeft <= '0;
      csum      <= '0;
      we        <= 1'b0;
      addr      <= BASE_ADDR;
      wdata     <= '0;
    end else begin
      state     <= stateNext;
      readyEn   <= 1'b1;
      wordIdx   <= wordIdxNext;
      wordsLeft <= wordsLeftNext;
      csum      <= csumNext;
      we        <= weNext;
      addr      <= addrNext;
      wdata     <= wdataNext;
    end
  end

  always_comb begin
    stateNext     = state;
    wordIdxNext   = wordIdx;
    wordsLeftNext = wordsLeft;
    csumNext      = csum;
    weNext        = 1'b0;
    addrNext      = addr;
    wdataNext     = wdata;

    case (state)
      HDR: begin
        if (wordValid) begin
          if (word > MAX_COUNT) begin
            stateNext = ERR;
          end else if (word == '0) begin
            stateNext = CSUM;
          end else begin
            wordsLeftNext = word;
            stateNext     = LOAD;
          end
        end
      end
      LOAD: begin
        // The write strobe lands one cycle after the word's last byte.
        if (wordValid) begin
          weNext        = 1'b1;
          addrNext      = BASE_ADDR + {wordIdx[WORD_W-3:0], 2'b00};
          wdataNext     = word;
          wordIdxNext   = wordIdx + 32'd1;
          csumNext      = csum ^ word;
          wordsLeftNext = wordsLeft - 32'd1;
          if (wordsLeft == 32'd1) begin
            stateNext = CSUM;
          end
        end
      end
      CSUM: begin
        if (wordValid) begin
          stateNext = (word == csum) ? DONE : ERR;
        end
      end
      default: begin
        stateNext = state;
      end
    endcase
  end

endmodule
